// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointers for the sample-capture (clk_wr) to
// filter-datapath (clk_rd) crossing. Only the registered Gray pointers cross
// domains, each through a SYNC_STAGES-deep flop chain. Full/empty, occupancy
// counts and thresholds are registered in their own domain, and so are the
// sticky overflow/underflow flags.
module async_fifo_gray #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 6,
    parameter int AE_THRESH   = 1
) (
    input  logic              clk_wr,
    input  logic              rst,
    input  logic              clk_rd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_count,
    output logic              overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_count,
    output logic              underflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] AF_LIMIT = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

    // Binary to Gray: adjacent codes differ in exactly one bit.
    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [1:0]        wr_rst_sync_r;
    logic              wr_rst_s;
    logic [PTR_W-1:0]  wr_bin_r;
    logic [PTR_W-1:0]  wr_gray_r;
    logic [PTR_W-1:0]  rd_gray_sync_r [SYNC_STAGES];
    logic              full_r;
    logic              almost_full_r;
    logic [PTR_W-1:0]  wr_count_r;
    logic              overflow_r;
    logic              wr_inc_s;
    logic [PTR_W-1:0]  wr_bin_next_s;
    logic [PTR_W-1:0]  wr_gray_next_s;
    logic [PTR_W-1:0]  rd_gray_seen_s;
    logic              full_next_s;
    logic [PTR_W-1:0]  wr_count_next_s;

    // Write-domain reset: asserts with rst, releases two clk_wr edges later.
    always_ff @(posedge clk_wr or posedge rst) begin
        if (rst) begin
            wr_rst_sync_r <= 2'b11;
        end else begin
            wr_rst_sync_r <= {wr_rst_sync_r[0], 1'b0};
        end
    end

    assign wr_rst_s = wr_rst_sync_r[1];

    // Next write pointer, full prediction and occupancy from the synced read pointer.
    always_comb begin
        wr_inc_s        = 1'b0;
        wr_bin_next_s   = wr_bin_r;
        wr_gray_next_s  = wr_gray_r;
        rd_gray_seen_s  = rd_gray_sync_r[SYNC_STAGES-1];
        full_next_s     = 1'b0;
        wr_count_next_s = {PTR_W{1'b0}};
        if (wr_en && !full_r) begin
            wr_inc_s = 1'b1;
        end else begin
            wr_inc_s = 1'b0;
        end
        wr_bin_next_s   = wr_bin_r + {{ADDR_W{1'b0}}, wr_inc_s};
        wr_gray_next_s  = bin2gray(wr_bin_next_s);
        full_next_s     = (wr_gray_next_s ==
                           {~rd_gray_seen_s[PTR_W-1:PTR_W-2], rd_gray_seen_s[PTR_W-3:0]});
        wr_count_next_s = wr_bin_next_s - gray2bin(rd_gray_seen_s);
    end

    // Read pointer synchroniser into clk_wr.
    always_ff @(posedge clk_wr or posedge wr_rst_s) begin
        if (wr_rst_s) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_gray_sync_r[i] <= {PTR_W{1'b0}};
            end
        end else begin
            rd_gray_sync_r[0] <= rd_gray_r;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_gray_sync_r[i] <= rd_gray_sync_r[i-1];
            end
        end
    end

    // Write pointer, flags, occupancy and sticky overflow.
    always_ff @(posedge clk_wr or posedge wr_rst_s) begin
        if (wr_rst_s) begin
            wr_bin_r      <= {PTR_W{1'b0}};
            wr_gray_r     <= {PTR_W{1'b0}};
            full_r        <= 1'b0;
            almost_full_r <= 1'b0;
            wr_count_r    <= {PTR_W{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            wr_bin_r      <= wr_bin_next_s;
            wr_gray_r     <= wr_gray_next_s;
            full_r        <= full_next_s;
            almost_full_r <= (wr_count_next_s >= AF_LIMIT);
            wr_count_r    <= wr_count_next_s;
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Storage write; the array itself carries no reset.
    always_ff @(posedge clk_wr) begin
        if (wr_inc_s && !wr_rst_s) begin
            mem[wr_bin_r[ADDR_W-1:0]] <= wr_data;
        end
    end

    // ---------------- read domain ----------------
    logic [1:0]        rd_rst_sync_r;
    logic              rd_rst_s;
    logic [PTR_W-1:0]  rd_bin_r;
    logic [PTR_W-1:0]  rd_gray_r;
    logic [PTR_W-1:0]  wr_gray_sync_r [SYNC_STAGES];
    logic              empty_r;
    logic              almost_empty_r;
    logic [PTR_W-1:0]  rd_count_r;
    logic              underflow_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              rd_inc_s;
    logic [PTR_W-1:0]  rd_bin_next_s;
    logic [PTR_W-1:0]  rd_gray_next_s;
    logic [PTR_W-1:0]  wr_gray_seen_s;
    logic [PTR_W-1:0]  rd_count_next_s;

    // Read-domain reset: asserts with rst, releases two clk_rd edges later.
    always_ff @(posedge clk_rd or posedge rst) begin
        if (rst) begin
            rd_rst_sync_r <= 2'b11;
        end else begin
            rd_rst_sync_r <= {rd_rst_sync_r[0], 1'b0};
        end
    end

    assign rd_rst_s = rd_rst_sync_r[1];

    // Next read pointer and occupancy from the synced write pointer.
    always_comb begin
        rd_inc_s        = 1'b0;
        rd_bin_next_s   = rd_bin_r;
        rd_gray_next_s  = rd_gray_r;
        wr_gray_seen_s  = wr_gray_sync_r[SYNC_STAGES-1];
        rd_count_next_s = {PTR_W{1'b0}};
        if (rd_en && !empty_r) begin
            rd_inc_s = 1'b1;
        end else begin
            rd_inc_s = 1'b0;
        end
        rd_bin_next_s   = rd_bin_r + {{ADDR_W{1'b0}}, rd_inc_s};
        rd_gray_next_s  = bin2gray(rd_bin_next_s);
        rd_count_next_s = gray2bin(wr_gray_seen_s) - rd_bin_next_s;
    end

    // Write pointer synchroniser into clk_rd.
    always_ff @(posedge clk_rd or posedge rd_rst_s) begin
        if (rd_rst_s) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wr_gray_sync_r[i] <= {PTR_W{1'b0}};
            end
        end else begin
            wr_gray_sync_r[0] <= wr_gray_r;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wr_gray_sync_r[i] <= wr_gray_sync_r[i-1];
            end
        end
    end

    // Read pointer, registered read port, flags, occupancy and sticky underflow.
    always_ff @(posedge clk_rd or posedge rd_rst_s) begin
        if (rd_rst_s) begin
            rd_bin_r       <= {PTR_W{1'b0}};
            rd_gray_r      <= {PTR_W{1'b0}};
            empty_r        <= 1'b1;
            almost_empty_r <= 1'b1;
            rd_count_r     <= {PTR_W{1'b0}};
            underflow_r    <= 1'b0;
            rd_data_r      <= {DATA_W{1'b0}};
            rd_valid_r     <= 1'b0;
        end else begin
            rd_bin_r       <= rd_bin_next_s;
            rd_gray_r      <= rd_gray_next_s;
            empty_r        <= (rd_gray_next_s == wr_gray_seen_s);
            almost_empty_r <= (rd_count_next_s <= AE_LIMIT);
            rd_count_r     <= rd_count_next_s;
            rd_valid_r     <= rd_inc_s;
            if (rd_inc_s) begin
                rd_data_r <= mem[rd_bin_r[ADDR_W-1:0]];
            end
            if (rd_en && empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign full         = full_r;
    assign almost_full  = almost_full_r;
    assign wr_count     = wr_count_r;
    assign overflow     = overflow_r;
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign empty        = empty_r;
    assign almost_empty = almost_empty_r;
    assign rd_count     = rd_count_r;
    assign underflow    = underflow_r;

endmodule
